audio_rec_ctrl: RTL and testbench

Record/playback sequencer for the PDM microphone capture path. Generates the microphone bit clock and a one-cycle sample strobe, and drives the `wr`/`rd` level controls of the `microfono` capture/buffer core. Bounds every recording by length, buffer-full or user stop, and replays exactly the recorded number of samples. Sits between the user/CPU control registers and `microfono`, which holds the sample buffer.

---
 rtl/audio_rec_ctrl_if.sv | 30 +++
 rtl/audio_rec_ctrl.sv | 141 ++++++++++++++
 tb/tb_audio_rec_ctrl.sv | 228 ++++++++++++++++++++++
 3 files changed

// File: rtl/audio_rec_ctrl_if.sv
// Control/status bundle between the user/CPU registers and the record/playback sequencer.
// The master drives the requests and capture-core flags; the slave (sequencer) drives the rest.
interface audio_rec_ctrl_if #(
    parameter int CW = 11
);
    logic          start_rec;
    logic          start_play;
    logic          stop;
    logic          full;
    logic          empty;
    logic          mic_clk;
    logic          sample_en;
    logic          wr;
    logic          rd;
    logic          busy;
    logic          done;
    logic [CW-1:0] count;
    logic [CW-1:0] len;
    logic [1:0]    state;

    modport master (
        output start_rec, start_play, stop, full, empty,
        input  mic_clk, sample_en, wr, rd, busy, done, count, len, state
    );

    modport slave (
        input  start_rec, start_play, stop, full, empty,
        output mic_clk, sample_en, wr, rd, busy, done, count, len, state
    );
endinterface

// File: rtl/audio_rec_ctrl.sv
// Record/playback sequencer for the PDM microphone path: generates mic_clk and the
// sample strobe, drives wr/rd of the capture core and bounds/replays recordings.
module audio_rec_ctrl #(
    parameter int DIV     = 4,
    parameter int REC_LEN = 1024,
    parameter int CW      = 11
) (
    input  logic             clk,
    input  logic             reset,
    audio_rec_ctrl_if.slave  bus
);
    localparam int DW = (DIV > 2) ? $clog2(DIV) : 1;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_RECORD = 2'd1,
        S_PLAY   = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    state_t        state_q, state_d;
    logic [DW-1:0] div_q, div_d;
    logic          mic_clk_q, mic_clk_d;
    logic          sample_en_q, sample_en_d;
    logic          wr_q, wr_d;
    logic          rd_q, rd_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic [CW-1:0] count_q, count_d;
    logic [CW-1:0] len_q, len_d;

    logic          tick;
    logic          rise;
    logic          is_rec;
    logic          abort;
    logic          finish;
    logic [CW-1:0] cnt_inc;
    logic [CW-1:0] limit;

    always_comb begin
        state_d     = state_q;
        div_d       = div_q;
        mic_clk_d   = mic_clk_q;
        sample_en_d = 1'b0;
        wr_d        = wr_q;
        rd_d        = rd_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        count_d     = count_q;
        len_d       = len_q;
        finish      = 1'b0;

        tick    = (div_q == DW'(DIV - 1));
        rise    = tick && !mic_clk_q;
        is_rec  = (state_q == S_RECORD);
        abort   = bus.stop || (is_rec ? bus.full : bus.empty);
        cnt_inc = count_q + 1'b1;
        limit   = is_rec ? CW'(REC_LEN) : len_q;

        case (state_q)
            S_IDLE: begin
                div_d     = '0;
                mic_clk_d = 1'b0;
                if (bus.start_rec) begin
                    state_d = S_RECORD;
                    count_d = '0;
                    wr_d    = 1'b1;
                    busy_d  = 1'b1;
                end else if (bus.start_play && (len_q != '0)) begin
                    state_d = S_PLAY;
                    count_d = '0;
                    rd_d    = 1'b1;
                    busy_d  = 1'b1;
                end
            end
            S_RECORD, S_PLAY: begin
                // An abort suppresses any rise that would have happened on the same edge.
                if (abort) begin
                    finish = 1'b1;
                end else begin
                    div_d = tick ? '0 : div_q + 1'b1;
                    if (tick) mic_clk_d = ~mic_clk_q;
                    if (rise) begin
                        count_d     = cnt_inc;
                        sample_en_d = 1'b1;
                        if (cnt_inc == limit) finish = 1'b1;
                    end
                end
                if (finish) begin
                    state_d   = S_DONE;
                    done_d    = 1'b1;
                    wr_d      = 1'b0;
                    rd_d      = 1'b0;
                    busy_d    = 1'b0;
                    mic_clk_d = 1'b0;
                    div_d     = '0;
                    if (is_rec) len_d = count_d;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            div_q       <= '0;
            mic_clk_q   <= 1'b0;
            sample_en_q <= 1'b0;
            wr_q        <= 1'b0;
            rd_q        <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            count_q     <= '0;
            len_q       <= '0;
        end else begin
            state_q     <= state_d;
            div_q       <= div_d;
            mic_clk_q   <= mic_clk_d;
            sample_en_q <= sample_en_d;
            wr_q        <= wr_d;
            rd_q        <= rd_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            count_q     <= count_d;
            len_q       <= len_d;
        end
    end

    assign bus.mic_clk   = mic_clk_q;
    assign bus.sample_en = sample_en_q;
    assign bus.wr        = wr_q;
    assign bus.rd        = rd_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.count     = count_q;
    assign bus.len       = len_q;
    assign bus.state     = state_q;
endmodule

// File: tb/tb_audio_rec_ctrl.sv
// Directed bench for audio_rec_ctrl: expected strobe/done events are queued when a
// start is driven and consumed as the DUTs produce them.
module tb_audio_rec_ctrl;
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    audio_rec_ctrl_if #(.CW(11)) if1 ();
    audio_rec_ctrl_if #(.CW(11)) if2 ();

    audio_rec_ctrl #(.DIV(4), .REC_LEN(8), .CW(11)) u1 (.clk(clk), .reset(reset), .bus(if1));
    audio_rec_ctrl #(.DIV(2), .REC_LEN(1), .CW(11)) u2 (.clk(clk), .reset(reset), .bus(if2));

    typedef struct {
        int cyc;
        int cnt;
        int ln;
    } ev_t;

    ev_t sq1[$];
    ev_t dq1[$];
    ev_t sq2[$];
    ev_t dq2[$];

    int checks = 0;
    int errors = 0;
    int wr1 = 0, rd1 = 0, wr2 = 0;
    int e0, base;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Advance to the next falling edge and score any strobe/done the DUTs show there.
    task automatic step();
        ev_t e;
        @(negedge clk);
        if (if1.sample_en) begin
            if (sq1.size() == 0) check("u1_unexpected_sample_en", 1, 0);
            else begin
                e = sq1.pop_front();
                check("u1_sample_cycle", cyc, e.cyc);
                check("u1_sample_count", if1.count, e.cnt);
            end
        end
        if (if1.done) begin
            if (dq1.size() == 0) check("u1_unexpected_done", 1, 0);
            else begin
                e = dq1.pop_front();
                check("u1_done_cycle", cyc, e.cyc);
                check("u1_done_count", if1.count, e.cnt);
                check("u1_done_len", if1.len, e.ln);
                check("u1_done_state", if1.state, 3);
            end
        end
        if (if2.sample_en) begin
            if (sq2.size() == 0) check("u2_unexpected_sample_en", 1, 0);
            else begin
                e = sq2.pop_front();
                check("u2_sample_cycle", cyc, e.cyc);
                check("u2_sample_count", if2.count, e.cnt);
            end
        end
        if (if2.done) begin
            if (dq2.size() == 0) check("u2_unexpected_done", 1, 0);
            else begin
                e = dq2.pop_front();
                check("u2_done_cycle", cyc, e.cyc);
                check("u2_done_count", if2.count, e.cnt);
                check("u2_done_len", if2.len, e.ln);
            end
        end
        if (if1.wr) wr1++;
        if (if1.rd) rd1++;
        if (if2.wr) wr2++;
    endtask

    task automatic run_until(input int c);
        while (cyc < c) step();
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_u1_ctrl"}, {if1.state, if1.wr, if1.rd, if1.busy, if1.done, if1.mic_clk, if1.sample_en}, 0);
        check({tag, "_u1_count"}, if1.count, 0);
        check({tag, "_u1_len"}, if1.len, 0);
        check({tag, "_u2_ctrl"}, {if2.state, if2.wr, if2.busy, if2.done, if2.mic_clk, if2.sample_en, if2.len}, 0);
    endtask

    initial begin
        reset = 1'b1;
        {if1.start_rec, if1.start_play, if1.stop, if1.full, if1.empty} = '0;
        {if2.start_rec, if2.start_play, if2.stop, if2.full, if2.empty} = '0;
        repeat (3) step();
        check_zero("reset");
        reset = 1'b0;
        step();

        // start_play with len==0 is ignored
        if1.start_play = 1'b1; step(); if1.start_play = 1'b0;
        repeat (3) step();
        check("play_len0_state", if1.state, 0);

        // full-length recording
        e0 = cyc + 1;
        for (int k = 1; k <= 8; k++) sq1.push_back('{e0 + 4 + (k - 1) * 8, k, 0});
        dq1.push_back('{e0 + 60, 8, 8});
        base = wr1;
        if1.start_rec = 1'b1; step(); if1.start_rec = 1'b0;
        check("rec_entry_state", if1.state, 1);
        check("rec_entry_wr_rd_busy", {if1.wr, if1.rd, if1.busy}, 3'b101);
        run_until(e0 + 62);
        check("rec_wr_cycles", wr1 - base, 60);
        check("rec_len", if1.len, 8);
        check("rec_count_hold", if1.count, 8);
        check("rec_back_idle", if1.state, 0);
        check("rec_pending", sq1.size() + dq1.size(), 0);

        // full-length playback
        e0 = cyc + 1;
        for (int k = 1; k <= 8; k++) sq1.push_back('{e0 + 4 + (k - 1) * 8, k, 0});
        dq1.push_back('{e0 + 60, 8, 8});
        base = rd1;
        if1.start_play = 1'b1; step(); if1.start_play = 1'b0;
        check("play_entry_state", if1.state, 2);
        run_until(e0 + 62);
        check("play_rd_cycles", rd1 - base, 60);
        check("play_len_kept", if1.len, 8);
        check("play_pending", sq1.size() + dq1.size(), 0);

        // full between 3rd and 4th rise
        e0 = cyc + 1;
        for (int k = 1; k <= 3; k++) sq1.push_back('{e0 + 4 + (k - 1) * 8, k, 0});
        dq1.push_back('{e0 + 24, 3, 3});
        if1.start_rec = 1'b1; step(); if1.start_rec = 1'b0;
        run_until(e0 + 23);
        if1.full = 1'b1; step(); if1.full = 1'b0;
        run_until(e0 + 26);
        check("full_mid_len", if1.len, 3);
        check("full_mid_pending", sq1.size() + dq1.size(), 0);

        // full on the 2nd rise edge suppresses that rise
        e0 = cyc + 1;
        sq1.push_back('{e0 + 4, 1, 0});
        dq1.push_back('{e0 + 12, 1, 1});
        if1.start_rec = 1'b1; step(); if1.start_rec = 1'b0;
        run_until(e0 + 11);
        if1.full = 1'b1; step(); if1.full = 1'b0;
        run_until(e0 + 14);
        check("full_rise_len", if1.len, 1);
        check("full_rise_pending", sq1.size() + dq1.size(), 0);

        // simultaneous starts: record wins; then stop after two samples
        e0 = cyc + 1;
        sq1.push_back('{e0 + 4, 1, 0});
        sq1.push_back('{e0 + 12, 2, 0});
        dq1.push_back('{e0 + 14, 2, 2});
        if1.start_rec = 1'b1; if1.start_play = 1'b1; step();
        if1.start_rec = 1'b0; if1.start_play = 1'b0;
        check("both_starts_state", if1.state, 1);
        run_until(e0 + 13);
        if1.stop = 1'b1; step(); if1.stop = 1'b0;
        run_until(e0 + 16);
        check("stop_rec_len", if1.len, 2);

        // playback: start_rec ignored, then stop
        e0 = cyc + 1;
        sq1.push_back('{e0 + 4, 1, 0});
        dq1.push_back('{e0 + 6, 1, 2});
        if1.start_play = 1'b1; step(); if1.start_play = 1'b0;
        run_until(e0 + 1);
        if1.start_rec = 1'b1; step(); if1.start_rec = 1'b0;
        check("play_ignores_rec_state", if1.state, 2);
        check("play_ignores_rec_wr", if1.wr, 0);
        run_until(e0 + 5);
        if1.stop = 1'b1; step(); if1.stop = 1'b0;
        run_until(e0 + 8);
        check("stop_play_len", if1.len, 2);
        check("stop_play_pending", sq1.size() + dq1.size(), 0);

        // empty on the first rise edge of playback
        e0 = cyc + 1;
        dq1.push_back('{e0 + 4, 0, 2});
        if1.start_play = 1'b1; step(); if1.start_play = 1'b0;
        run_until(e0 + 3);
        if1.empty = 1'b1; step(); if1.empty = 1'b0;
        run_until(e0 + 6);
        check("empty_count", if1.count, 0);
        check("empty_pending", sq1.size() + dq1.size(), 0);

        // asynchronous reset mid-recording
        e0 = cyc + 1;
        sq1.push_back('{e0 + 4, 1, 0});
        if1.start_rec = 1'b1; step(); if1.start_rec = 1'b0;
        run_until(e0 + 10);
        check("pre_reset_busy", if1.busy, 1);
        @(posedge clk);
        #2 reset = 1'b1;
        #1 check_zero("async_reset");
        step();
        reset = 1'b0;
        step();
        if1.start_play = 1'b1; step(); if1.start_play = 1'b0;
        repeat (3) step();
        check("post_reset_play_state", if1.state, 0);
        check("post_reset_pending", sq1.size() + dq1.size(), 0);

        // DIV=2, REC_LEN=1 instance
        e0 = cyc + 1;
        sq2.push_back('{e0 + 2, 1, 0});
        dq2.push_back('{e0 + 2, 1, 1});
        base = wr2;
        if2.start_rec = 1'b1; step(); if2.start_rec = 1'b0;
        run_until(e0 + 4);
        check("u2_wr_cycles", wr2 - base, 2);
        check("u2_len", if2.len, 1);
        check("u2_pending", sq2.size() + dq2.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
